mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single data-memory/device bus between the pipeline's MEM-stage load/store port (CPU) and a DMA/UART requester.
//  Arbitrates, issues one access at a time to memory, tracks read latency and returns data with a one-cycle ack pulse.
//  Drives cpu_stall so the pipeline freezes while a CPU access is pending. Sits between CPU bus outputs and the memory/device bus.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width
//  MEM_LATENCY   1   cycles from issue cycle to mem_rdata valid (>=1)
//  CPU_PRIORITY  1   1: fixed priority to CPU; 0: round robin
//  DMA_MAX_WAIT  4   consecutive lost arbitrations after which DMA wins the next (fixed-priority mode only; >=1)
// PORTS
//  clk        in   1       clock; all logic on rising edge
//  reset      in   1       synchronous, active-high
//  cpu_req    in   1       CPU access request; held with fields stable until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_rdata  out  DATA_W  read data, valid with cpu_ack
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_stall  out  1       cpu_req & ~cpu_ack (combinational)
//  dma_req / dma_we / dma_addr / dma_wdata / dma_rdata / dma_ack   same as cpu_* for DMA
//  mem_rd     out  1       read strobe, ISSUE cycle only
//  mem_wr     out  1       write strobe, ISSUE cycle only
//  mem_addr   out  ADDR_W  latched address of granted access
//  mem_wdata  out  DATA_W  latched write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LATENCY cycles after ISSUE
// BEHAVIOUR
//  Reset: state IDLE; all outputs, owner, latches, counters = 0; in-flight access abandoned, no ack issued.
//  FSM IDLE -> ISSUE -> (read: WAIT x MEM_LATENCY) -> RESP -> IDLE.
//   IDLE: if any req, pick owner, latch we/addr/wdata, go ISSUE; else stay.
//   ISSUE: mem_rd or mem_wr = 1 (registered), mem_addr/mem_wdata from latch; write -> RESP, read -> WAIT.
//   WAIT: down-counter from MEM_LATENCY; on last WAIT cycle capture mem_rdata; -> RESP.
//   RESP: owner ack = 1 for exactly one cycle, owner rdata = captured data (held until next capture); -> IDLE. Requests ignored.
//  Timing (req first seen in IDLE at cycle 0): write ack cycle 2; read ack cycle 2+MEM_LATENCY. Next grant earliest cycle after RESP.
//  Arbitration (IDLE, both req): CPU_PRIORITY=1: CPU wins unless dma_wait_cnt==DMA_MAX_WAIT; dma_wait_cnt++ when DMA loses, cleared when DMA granted.
//   CPU_PRIORITY=0: winner is the requester not granted last; last_owner reset = DMA (CPU wins first tie).
//  Only one req: that requester wins, no counter change except clear on DMA grant.
//  mem_rd/mem_wr never both 1; both 0 outside ISSUE. Non-owner ack always 0.
//  Req dropped before ack (protocol violation): access still completes, ack still pulses.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stat_cpu_grants, stat_dma_grants, stat_cpu_wait (32 bit each, saturating, reset 0);
//   grants increment on IDLE->ISSUE per owner; cpu_wait increments each cycle cpu_stall=1.
//  Undefined: ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  Shared package mem_arb_pkg: state encoding (IDLE/ISSUE/WAIT/RESP), owner encoding OWN_CPU/OWN_DMA, ADDR_W/DATA_W defaults.
//  Sub-module mem_arb_stats: the ARB_STATS_EN counters, instantiated only under the macro.
// TESTING
//  CPU read alone, MEM_LATENCY=1, addr 0x40, mem returns 0xDEADBEEF -> mem_rd pulse cycle 1, cpu_ack+rdata=0xDEADBEEF cycle 3, cpu_stall 1 cycles 0-2.
//  Simultaneous CPU write 0x10/0x11 and DMA read, CPU_PRIORITY=1 -> CPU ack cycle 2, DMA granted at next IDLE, DMA ack after its latency.
//  CPU req held continuously, DMA req held, DMA_MAX_WAIT=4 -> DMA loses 4 times, wins 5th arbitration; dma_wait_cnt returns to 0.
//  CPU_PRIORITY=0, both req held -> grants alternate CPU, DMA, CPU, DMA; never two consecutive to one owner.
//  Reset asserted during WAIT of MEM_LATENCY=3 read -> next cycle all outputs 0, state IDLE, no ack; fresh req served normally.
//  ARB_STATS_EN: 3 CPU + 2 DMA accesses -> stat_cpu_grants=3, stat_dma_grants=2; stat_cpu_wait equals cycles cpu_stall high.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, access owner and default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating grant and CPU-wait counters for the memory bus arbiter.
// Instantiated by mem_bus_arbiter only when ARB_STATS_EN is defined.
module mem_arb_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        grant_cpu,
    input  logic        grant_dma,
    input  logic        cpu_stall,
    output logic [31:0] stat_cpu_grants,
    output logic [31:0] stat_dma_grants,
    output logic [31:0] stat_cpu_wait
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cpu_grants <= '0;
            stat_dma_grants <= '0;
            stat_cpu_wait   <= '0;
        end else begin
            if (grant_cpu && (stat_cpu_grants != '1))
                stat_cpu_grants <= stat_cpu_grants + 1'b1;
            if (grant_dma && (stat_dma_grants != '1))
                stat_dma_grants <= stat_dma_grants + 1'b1;
            if (cpu_stall && (stat_cpu_wait != '1))
                stat_cpu_wait <= stat_cpu_wait + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory/device bus between the CPU MEM-stage port and the DMA/UART port.
// Optional statistics counters are built in when ARB_STATS_EN is defined.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | no access in flight; arbitrate and latch the winner's request
//  ST_ISSUE | mem_rd or mem_wr strobe high for one cycle
//  ST_WAIT  | read latency countdown; capture mem_rdata on the last cycle
//  ST_RESP  | one-cycle ack to the owner; new requests are ignored
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MEM_LATENCY  = 1,
    parameter int CPU_PRIORITY = 1,
    parameter int DMA_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_grants,
    output logic [31:0]       stat_dma_grants,
    output logic [31:0]       stat_cpu_wait
`endif
);

    localparam int LAT_W   = $clog2(MEM_LATENCY + 1);
    localparam int DWAIT_W = $clog2(DMA_MAX_WAIT + 1);

    arb_state_t         state;
    owner_t             owner;
    owner_t             last_owner;
    logic [LAT_W-1:0]   lat_cnt;
    logic [DWAIT_W-1:0] dma_wait_cnt;
    logic               any_req;
    logic               grant_dma;
    logic               sel_we;

    always_comb begin
        any_req   = cpu_req | dma_req;
        grant_dma = 1'b0;
        if (dma_req && !cpu_req) begin
            grant_dma = 1'b1;
        end else if (dma_req && cpu_req) begin
            if (CPU_PRIORITY != 0)
                grant_dma = (dma_wait_cnt == DWAIT_W'(DMA_MAX_WAIT));
            else
                grant_dma = (last_owner == OWN_CPU);
        end
        sel_we = grant_dma ? dma_we : cpu_we;
    end

    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            owner        <= OWN_CPU;
            last_owner   <= OWN_DMA;
            lat_cnt      <= '0;
            dma_wait_cnt <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_ack      <= 1'b0;
            dma_ack      <= 1'b0;
            cpu_rdata    <= '0;
            dma_rdata    <= '0;
        end else begin
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner      <= grant_dma ? OWN_DMA : OWN_CPU;
                        last_owner <= grant_dma ? OWN_DMA : OWN_CPU;
                        mem_addr   <= grant_dma ? dma_addr : cpu_addr;
                        mem_wdata  <= grant_dma ? dma_wdata : cpu_wdata;
                        mem_rd     <= ~sel_we;
                        mem_wr     <= sel_we;
                        if (grant_dma)
                            dma_wait_cnt <= '0;
                        else if ((CPU_PRIORITY != 0) && dma_req)
                            dma_wait_cnt <= dma_wait_cnt + 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // mem_wr is only ever high in ISSUE, so it doubles as the latched direction
                    if (mem_wr) begin
                        cpu_ack <= (owner == OWN_CPU);
                        dma_ack <= (owner == OWN_DMA);
                        state   <= ST_RESP;
                    end else begin
                        lat_cnt <= LAT_W'(MEM_LATENCY);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        if (owner == OWN_CPU) begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end else begin
                            dma_rdata <= mem_rdata;
                            dma_ack   <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic stat_grant_cpu;
    logic stat_grant_dma;

    assign stat_grant_cpu = (state == ST_IDLE) && any_req && !grant_dma;
    assign stat_grant_dma = (state == ST_IDLE) && grant_dma;

    mem_arb_stats u_stats (
        .clk             (clk),
        .reset           (reset),
        .grant_cpu       (stat_grant_cpu),
        .grant_dma       (stat_grant_dma),
        .cpu_stall       (cpu_stall),
        .stat_cpu_grants (stat_cpu_grants),
        .stat_dma_grants (stat_dma_grants),
        .stat_cpu_wait   (stat_cpu_wait)
    );
`endif

endmodule
